// File: rtl/branch_predictor_pkg.sv
// rtl/branch_predictor_pkg.sv - shared constants and counter encodings for the branch predictor
package branch_predictor_pkg;

    // Default number of BTB entries
    localparam int BP_ENTRIES = 16;

    // 2-bit saturating counter states
    typedef enum logic [1:0] {
        BP_SNT = 2'b00,
        BP_WNT = 2'b01,
        BP_WT  = 2'b10,
        BP_ST  = 2'b11
    } bp_ctr_e;

    // Counter value loaded on reset
    localparam bp_ctr_e BP_CTR_RST = BP_WNT;

    // Counter value given to a freshly allocated entry
    localparam bp_ctr_e BP_CTR_ALLOC = BP_WT;

endpackage

// File: rtl/sat_counter2.sv
// rtl/sat_counter2.sv - combinational 2-bit saturating increment/decrement
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  logic [1:0] ctr_i,
    input  logic       taken_i,
    output logic [1:0] ctr_o
);

    // Step towards strong-taken on taken, strong-not-taken otherwise, holding at the ends
    always_comb begin
        ctr_o = ctr_i;
        if (taken_i) begin
            if (ctr_i != BP_ST) begin
                ctr_o = ctr_i + 2'd1;
            end
        end else begin
            if (ctr_i != BP_SNT) begin
                ctr_o = ctr_i - 2'd1;
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit counters; optional perf counters under BP_PERF_CNT_EN
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int ENTRIES = BP_ENTRIES
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] fetch_PC,
    output logic [31:0] pred_PC,
    output logic        pred_taken,
    input  logic        upd_valid,
    input  logic [31:0] upd_PC,
    input  logic        upd_is_branch,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
`ifdef BP_PERF_CNT_EN
    input  logic        upd_mispredict,
    output logic [31:0] perf_br_cnt,
    output logic [31:0] perf_mis_cnt
`else
    input  logic        upd_mispredict
`endif
);

    localparam int IDX_WD = $clog2(ENTRIES);
    localparam int TAG_WD = 30 - IDX_WD;

    // Table lives in flops so the valid bits can be cleared asynchronously
    logic              valid_q [ENTRIES];
    logic [TAG_WD-1:0] tag_q   [ENTRIES];
    logic [29:0]       tgt_q   [ENTRIES];
    logic [1:0]        ctr_q   [ENTRIES];

    logic [IDX_WD-1:0] f_idx;
    logic [TAG_WD-1:0] f_tag;
    logic              f_hit;

    logic [IDX_WD-1:0] u_idx;
    logic [TAG_WD-1:0] u_tag;
    logic              u_en;
    logic              u_hit;
    logic [1:0]        u_ctr_step;

    logic              ent_we;
    logic              ent_valid_d;
    logic [TAG_WD-1:0] ent_tag_d;
    logic [29:0]       ent_tgt_d;
    logic [1:0]        ent_ctr_d;

    // Address bits below word alignment carry no information here
    logic unused_bits;
`ifdef BP_PERF_CNT_EN
    assign unused_bits = ^{fetch_PC[1:0], upd_PC[1:0], upd_target[1:0]};
`else
    assign unused_bits = ^{fetch_PC[1:0], upd_PC[1:0], upd_target[1:0], upd_mispredict};
`endif

    assign f_idx = fetch_PC[IDX_WD+1:2];
    assign f_tag = fetch_PC[31:IDX_WD+2];
    assign u_idx = upd_PC[IDX_WD+1:2];
    assign u_tag = upd_PC[31:IDX_WD+2];
    assign u_en  = upd_valid & upd_is_branch;

    // Zero-latency lookup against registered contents; same-cycle updates are not bypassed
    always_comb begin
        f_hit      = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
        pred_taken = f_hit & ctr_q[f_idx][1];
        pred_PC    = pred_taken ? {tgt_q[f_idx], 2'b00} : fetch_PC + 32'd4;
    end

    sat_counter2 u_sat_counter2 (
        .ctr_i   (ctr_q[u_idx]),
        .taken_i (upd_taken),
        .ctr_o   (u_ctr_step)
    );

    // Work out the single entry write implied by this cycle's resolution record
    always_comb begin
        u_hit       = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
        ent_we      = 1'b0;
        ent_valid_d = valid_q[u_idx];
        ent_tag_d   = tag_q[u_idx];
        ent_tgt_d   = tgt_q[u_idx];
        ent_ctr_d   = ctr_q[u_idx];
        if (u_en) begin
            if (u_hit) begin
                ent_we    = 1'b1;
                ent_ctr_d = u_ctr_step;
                if (upd_taken) begin
                    ent_tgt_d = upd_target[31:2];
                end
            end else if (upd_taken) begin
                // Allocation overwrites whatever aliases into this slot
                ent_we      = 1'b1;
                ent_valid_d = 1'b1;
                ent_tag_d   = u_tag;
                ent_tgt_d   = upd_target[31:2];
                ent_ctr_d   = BP_CTR_ALLOC;
            end
        end
    end

    // Table state: asynchronous clear, single-entry write per cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
                ctr_q[i]   <= BP_CTR_RST;
            end
        end else if (ent_we) begin
            valid_q[u_idx] <= ent_valid_d;
            tag_q[u_idx]   <= ent_tag_d;
            tgt_q[u_idx]   <= ent_tgt_d;
            ctr_q[u_idx]   <= ent_ctr_d;
        end
    end

`ifdef BP_PERF_CNT_EN
    logic [31:0] perf_br_cnt_q;
    logic [31:0] perf_br_cnt_d;
    logic [31:0] perf_mis_cnt_q;
    logic [31:0] perf_mis_cnt_d;

    // Count qualifying branch records and the mispredicted subset, wrapping naturally
    always_comb begin
        perf_br_cnt_d  = perf_br_cnt_q;
        perf_mis_cnt_d = perf_mis_cnt_q;
        if (u_en) begin
            perf_br_cnt_d = perf_br_cnt_q + 32'd1;
            if (upd_mispredict) begin
                perf_mis_cnt_d = perf_mis_cnt_q + 32'd1;
            end
        end
    end

    // Performance counter registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_br_cnt_q  <= '0;
            perf_mis_cnt_q <= '0;
        end else begin
            perf_br_cnt_q  <= perf_br_cnt_d;
            perf_mis_cnt_q <= perf_mis_cnt_d;
        end
    end

    assign perf_br_cnt  = perf_br_cnt_q;
    assign perf_mis_cnt = perf_mis_cnt_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed self-checking bench for branch_predictor (perf checks under BP_PERF_CNT_EN)
module tb_branch_predictor;

    logic        clk;
    logic        resetn;
    logic [31:0] fetch_PC;
    logic [31:0] pred_PC;
    logic        pred_taken;
    logic        upd_valid;
    logic [31:0] upd_PC;
    logic        upd_is_branch;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_mispredict;
`ifdef BP_PERF_CNT_EN
    logic [31:0] perf_br_cnt;
    logic [31:0] perf_mis_cnt;
`endif

    int n_cmp;
    int n_err;

    branch_predictor #(.ENTRIES(16)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .fetch_PC       (fetch_PC),
        .pred_PC        (pred_PC),
        .pred_taken     (pred_taken),
        .upd_valid      (upd_valid),
        .upd_PC         (upd_PC),
        .upd_is_branch  (upd_is_branch),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
`ifdef BP_PERF_CNT_EN
        .upd_mispredict (upd_mispredict),
        .perf_br_cnt    (perf_br_cnt),
        .perf_mis_cnt   (perf_mis_cnt)
`else
        .upd_mispredict (upd_mispredict)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_update(input logic [31:0] pc, input logic br, input logic tk,
                             input logic [31:0] tgt, input logic mis);
        upd_valid      = 1'b1;
        upd_PC         = pc;
        upd_is_branch  = br;
        upd_taken      = tk;
        upd_target     = tgt;
        upd_mispredict = mis;
        @(posedge clk);
        #1;
        upd_valid      = 1'b0;
        upd_mispredict = 1'b0;
    endtask

    task automatic look(input logic [31:0] pc);
        fetch_PC = pc;
        #1;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        fetch_PC = 32'h1C00_0000;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (pred_taken !== 1'b0) begin
            n_err++;
            $display("FAIL reset_taken got %0b want 0", pred_taken);
        end
        n_cmp++;
        if (pred_PC !== 32'h1C00_0004) begin
            n_err++;
            $display("FAIL reset_pc got %h want 1c000004", pred_PC);
        end
        resetn = 1'b1;
        @(posedge clk);
        #1;
        look(32'h1C00_0000);
        n_cmp++;
        if (pred_PC !== 32'h1C00_0004 || pred_taken !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset got %h/%0b want 1c000004/0", pred_PC, pred_taken);
        end
    endtask

    task automatic test_alloc;
        do_update(32'h1C00_0010, 1'b1, 1'b1, 32'h1C00_0100, 1'b0);
        look(32'h1C00_0010);
        n_cmp++;
        if (pred_taken !== 1'b1 || pred_PC !== 32'h1C00_0100) begin
            n_err++;
            $display("FAIL alloc got %h/%0b want 1c000100/1", pred_PC, pred_taken);
        end
    endtask

    task automatic test_counter;
        do_update(32'h1C00_0010, 1'b1, 1'b0, 32'h1C00_0014, 1'b0);
        look(32'h1C00_0010);
        n_cmp++;
        if (pred_taken !== 1'b0) begin
            n_err++;
            $display("FAIL ctr_wnt got %0b want 0", pred_taken);
        end
        do_update(32'h1C00_0010, 1'b1, 1'b0, 32'h1C00_0014, 1'b0);
        look(32'h1C00_0010);
        n_cmp++;
        if (pred_PC !== 32'h1C00_0014 || pred_taken !== 1'b0) begin
            n_err++;
            $display("FAIL ctr_snt got %h/%0b want 1c000014/0", pred_PC, pred_taken);
        end
        do_update(32'h1C00_0010, 1'b1, 1'b0, 32'h1C00_0014, 1'b0);
        do_update(32'h1C00_0010, 1'b1, 1'b1, 32'h1C00_0100, 1'b0);
        look(32'h1C00_0010);
        n_cmp++;
        if (pred_taken !== 1'b0 || pred_PC !== 32'h1C00_0014) begin
            n_err++;
            $display("FAIL ctr_sat_low got %h/%0b want 1c000014/0", pred_PC, pred_taken);
        end
        do_update(32'h1C00_0010, 1'b1, 1'b1, 32'h1C00_0200, 1'b0);
        look(32'h1C00_0010);
        n_cmp++;
        if (pred_taken !== 1'b1 || pred_PC !== 32'h1C00_0200) begin
            n_err++;
            $display("FAIL ctr_retarget got %h/%0b want 1c000200/1", pred_PC, pred_taken);
        end
        do_update(32'h1C00_0010, 1'b1, 1'b1, 32'h1C00_0200, 1'b0);
        do_update(32'h1C00_0010, 1'b1, 1'b1, 32'h1C00_0200, 1'b0);
        do_update(32'h1C00_0010, 1'b1, 1'b0, 32'h1C00_0014, 1'b0);
        look(32'h1C00_0010);
        n_cmp++;
        if (pred_taken !== 1'b1 || pred_PC !== 32'h1C00_0200) begin
            n_err++;
            $display("FAIL ctr_sat_high got %h/%0b want 1c000200/1", pred_PC, pred_taken);
        end
    endtask

    task automatic test_no_update;
        do_update(32'h1C00_0030, 1'b0, 1'b1, 32'h1C00_0300, 1'b0);
        upd_valid = 1'b0;
        upd_PC = 32'h1C00_0034;
        upd_is_branch = 1'b1;
        upd_taken = 1'b1;
        upd_target = 32'h1C00_0340;
        @(posedge clk);
        #1;
        do_update(32'h1C00_0040, 1'b1, 1'b0, 32'h1C00_0044, 1'b0);
        look(32'h1C00_0030);
        n_cmp++;
        if (pred_taken !== 1'b0 || pred_PC !== 32'h1C00_0034) begin
            n_err++;
            $display("FAIL non_branch got %h/%0b want 1c000034/0", pred_PC, pred_taken);
        end
        look(32'h1C00_0034);
        n_cmp++;
        if (pred_taken !== 1'b0 || pred_PC !== 32'h1C00_0038) begin
            n_err++;
            $display("FAIL upd_invalid got %h/%0b want 1c000038/0", pred_PC, pred_taken);
        end
        look(32'h1C00_0040);
        n_cmp++;
        if (pred_taken !== 1'b0 || pred_PC !== 32'h1C00_0044) begin
            n_err++;
            $display("FAIL miss_nt_alloc got %h/%0b want 1c000044/0", pred_PC, pred_taken);
        end
    endtask

    task automatic test_alias;
        do_update(32'h1C00_0050, 1'b1, 1'b1, 32'h1C00_0500, 1'b0);
        look(32'h1C00_0010);
        n_cmp++;
        if (pred_taken !== 1'b0 || pred_PC !== 32'h1C00_0014) begin
            n_err++;
            $display("FAIL alias_evict got %h/%0b want 1c000014/0", pred_PC, pred_taken);
        end
        look(32'h1C00_0050);
        n_cmp++;
        if (pred_taken !== 1'b1 || pred_PC !== 32'h1C00_0500) begin
            n_err++;
            $display("FAIL alias_new got %h/%0b want 1c000500/1", pred_PC, pred_taken);
        end
    endtask

    task automatic test_same_cycle;
        fetch_PC       = 32'h1C00_0020;
        upd_valid      = 1'b1;
        upd_PC         = 32'h1C00_0020;
        upd_is_branch  = 1'b1;
        upd_taken      = 1'b1;
        upd_target     = 32'h1C00_0800;
        #1;
        n_cmp++;
        if (pred_taken !== 1'b0 || pred_PC !== 32'h1C00_0024) begin
            n_err++;
            $display("FAIL same_cycle_pre got %h/%0b want 1c000024/0", pred_PC, pred_taken);
        end
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        #1;
        n_cmp++;
        if (pred_taken !== 1'b1 || pred_PC !== 32'h1C00_0800) begin
            n_err++;
            $display("FAIL same_cycle_post got %h/%0b want 1c000800/1", pred_PC, pred_taken);
        end
    endtask

    task automatic test_wrap;
        look(32'hFFFF_FFFC);
        n_cmp++;
        if (pred_taken !== 1'b0 || pred_PC !== 32'h0000_0000) begin
            n_err++;
            $display("FAIL pc_wrap got %h/%0b want 00000000/0", pred_PC, pred_taken);
        end
    endtask

    task automatic test_async_reset;
        look(32'h1C00_0020);
        #2;
        resetn = 1'b0;
        #1;
        n_cmp++;
        if (pred_taken !== 1'b0 || pred_PC !== 32'h1C00_0024) begin
            n_err++;
            $display("FAIL async_clear got %h/%0b want 1c000024/0", pred_PC, pred_taken);
        end
        @(posedge clk);
        #1;
        resetn = 1'b1;
        do_update(32'h1C00_0050, 1'b1, 1'b1, 32'h1C00_0500, 1'b0);
        upd_valid      = 1'b1;
        upd_PC         = 32'h1C00_0060;
        upd_is_branch  = 1'b1;
        upd_taken      = 1'b1;
        upd_target     = 32'h1C00_0600;
        #2;
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn    = 1'b1;
        upd_valid = 1'b0;
        look(32'h1C00_0060);
        n_cmp++;
        if (pred_taken !== 1'b0 || pred_PC !== 32'h1C00_0064) begin
            n_err++;
            $display("FAIL reset_discard got %h/%0b want 1c000064/0", pred_PC, pred_taken);
        end
        look(32'h1C00_0050);
        n_cmp++;
        if (pred_taken !== 1'b0 || pred_PC !== 32'h1C00_0054) begin
            n_err++;
            $display("FAIL reset_clear got %h/%0b want 1c000054/0", pred_PC, pred_taken);
        end
    endtask

`ifdef BP_PERF_CNT_EN
    task automatic test_perf;
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        n_cmp++;
        if (perf_br_cnt !== 32'd0 || perf_mis_cnt !== 32'd0) begin
            n_err++;
            $display("FAIL perf_init got %0d/%0d want 0/0", perf_br_cnt, perf_mis_cnt);
        end
        do_update(32'h1C00_0100, 1'b1, 1'b1, 32'h1C00_1000, 1'b1);
        do_update(32'h1C00_0104, 1'b0, 1'b1, 32'h1C00_1000, 1'b1);
        do_update(32'h1C00_0108, 1'b1, 1'b0, 32'h1C00_010C, 1'b0);
        do_update(32'h1C00_010C, 1'b0, 1'b0, 32'h1C00_0110, 1'b0);
        do_update(32'h1C00_0100, 1'b1, 1'b0, 32'h1C00_0104, 1'b1);
        do_update(32'h1C00_0110, 1'b1, 1'b1, 32'h1C00_2000, 1'b0);
        do_update(32'h1C00_0114, 1'b0, 1'b1, 32'h1C00_2000, 1'b0);
        do_update(32'h1C00_0118, 1'b1, 1'b0, 32'h1C00_011C, 1'b0);
        n_cmp++;
        if (perf_br_cnt !== 32'd5) begin
            n_err++;
            $display("FAIL perf_br got %0d want 5", perf_br_cnt);
        end
        n_cmp++;
        if (perf_mis_cnt !== 32'd2) begin
            n_err++;
            $display("FAIL perf_mis got %0d want 2", perf_mis_cnt);
        end
        resetn = 1'b0;
        #1;
        n_cmp++;
        if (perf_br_cnt !== 32'd0 || perf_mis_cnt !== 32'd0) begin
            n_err++;
            $display("FAIL perf_reset got %0d/%0d want 0/0", perf_br_cnt, perf_mis_cnt);
        end
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask
`endif

    initial begin
        n_cmp          = 0;
        n_err          = 0;
        resetn         = 1'b0;
        fetch_PC       = 32'h0;
        upd_valid      = 1'b0;
        upd_PC         = 32'h0;
        upd_is_branch  = 1'b0;
        upd_taken      = 1'b0;
        upd_target     = 32'h0;
        upd_mispredict = 1'b0;
        test_reset;
        test_alloc;
        test_counter;
        test_no_update;
        test_alias;
        test_same_cycle;
        test_wrap;
        test_async_reset;
`ifdef BP_PERF_CNT_EN
        test_perf;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter: ENTRIES, 16, number of BTB entries (power of two, 4..64); index bits IDX_WD = log2(ENTRIES).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: resetn  input  1  asynchronous, active-low reset.
REQ-004 Port: fetch_PC  input  32  PC of instruction being fetched; bits [1:0] ignored.
REQ-005 Port: pred_PC  output  32  predicted next PC, fed to the branch-resolution stage.
REQ-006 Port: pred_taken  output  1  1 = BTB hit with taken prediction.
REQ-007 Port: upd_valid  input  1  resolution record valid this cycle.
REQ-008 Port: upd_PC  input  32  PC of resolved instruction.
REQ-009 Port: upd_is_branch  input  1  resolved instruction is jirl/b/beq/bne/bl.
REQ-010 Port: upd_taken  input  1  resolved next PC != upd_PC+4.
REQ-011 Port: upd_target  input  32  resolved next PC.
REQ-012 Port: upd_mispredict  input  1  cancel flag from branch resolution; perf counting only.

Function
REQ-013 Entry fields: valid, tag = PC[31:IDX_WD+2], target[31:2], 2-bit saturating counter; index = PC[IDX_WD+1:2].
REQ-014 Lookup is combinational from fetch_PC against registered table contents; zero-cycle latency.
REQ-015 Hit = entry valid and tag equal; pred_taken = hit & counter[1].
REQ-016 pred_PC = pred_taken ? {target,2'b00} : fetch_PC+4, with 32-bit wrap (0xFFFF_FFFC+4 = 0x0000_0000).
REQ-017 Updates act only when upd_valid & upd_is_branch; a non-branch record changes no state.
REQ-018 Update hit, taken: counter increments, saturating at 2'b11; target rewritten with upd_target[31:2].
REQ-019 Update hit, not taken: counter decrements, saturating at 2'b00; entry stays valid; target unchanged.
REQ-020 Update miss, taken: allocate (overwrite any occupant): valid=1, new tag, target, counter=2'b10.
REQ-021 Update miss, not taken: no allocation, no state change.
REQ-022 Lookup and update same cycle, same index: lookup returns pre-update contents; new contents visible next cycle (no bypass).
REQ-023 Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.

Reset
REQ-024 resetn low: all valid bits cleared immediately (asynchronous); counters 2'b01; targets/tags don't-care.
REQ-025 During and after reset until first allocation: pred_taken=0, pred_PC=fetch_PC+4.
REQ-026 Reset asserted while an update is presented: update discarded; state equals post-reset state.

Configuration
REQ-027 Macro BP_PERF_CNT_EN defined: outputs perf_br_cnt[31:0] (counts qualifying updates, REQ-017) and perf_mis_cnt[31:0] (counts qualifying updates with upd_mispredict=1); both reset to 0, wrap at 2^32.
REQ-028 Macro BP_PERF_CNT_EN undefined: those ports and counters absent; all other behaviour identical.

Structure
REQ-029 Shared header myCPU.h holds BP_ENTRIES default, counter encodings (BP_SNT/BP_WNT/BP_WT/BP_ST), counter reset value.
REQ-030 One sub-module sat_counter2: combinational 2-bit saturating inc/dec given current value and taken.
REQ-031 Table storage in flops (not inferred RAM) so asynchronous clear of valid is legal.

Verification
REQ-032 After reset, fetch_PC=0x1C00_0000 -> pred_taken=0, pred_PC=0x1C00_0004.
REQ-033 Update PC=0x1C00_0010, taken, target=0x1C00_0100; next cycle fetch 0x1C00_0010 -> pred_taken=1, pred_PC=0x1C00_0100.
REQ-034 Same entry: two not-taken updates -> counter 10->01->00; fetch -> pred_PC=0x1C00_0014; one taken update -> 01, still not taken.
REQ-035 Aliasing (ENTRIES=16): taken update PC=0x1C00_0050 evicts 0x1C00_0010 entry; fetch 0x1C00_0010 -> miss, pred_PC=0x1C00_0014.
REQ-036 Same-cycle update and lookup of 0x1C00_0020 (taken, first time) -> that cycle pred_taken=0; next cycle pred_taken=1.
REQ-037 With BP_PERF_CNT_EN: 5 branch updates, 2 with upd_mispredict, plus 3 non-branch updates -> perf_br_cnt=5, perf_mis_cnt=2; resetn low -> both 0.
